// File: rtl/aes_dec_pkg.sv
// Shared constants, types and GF(2^8) helpers for the AES-128 decryption key schedule.
// Defining AES_EQINV_KEY_EN adds inv_mix_columns for the equivalent-inverse-cipher read path.
package aes_dec_pkg;

  localparam int NR    = 10;
  localparam int KEY_W = 128;
  localparam int IDX_W = 4;

  localparam logic [7:0] RCON [1:NR] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  typedef logic [31:0]      word_t;
  typedef logic [KEY_W-1:0] state_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } ks_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

`ifdef AES_EQINV_KEY_EN
  // Multiply by a 4-bit constant (0x09/0x0b/0x0d/0x0e) using an xtime chain.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (k[3] ? x8 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^
           (k[1] ? x2 : 8'h00) ^ (k[0] ? a  : 8'h00);
  endfunction

  function automatic word_t inv_mix_column(input word_t c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
            gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
            gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
            gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
  endfunction

  function automatic state_t inv_mix_columns(input state_t s);
    state_t r;
    for (int i = 0; i < 4; i++) begin
      r[KEY_W-1-32*i -: 32] = inv_mix_column(s[KEY_W-1-32*i -: 32]);
    end
    return r;
  endfunction
`endif

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: one byte in, one byte out, purely combinational table lookup.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes_dec_key_sched.sv
// Iterative AES-128 key expansion serving round keys in decryption order (d -> rk[NR-d]).
// Defining AES_EQINV_KEY_EN returns InvMixColumns(rk) for d=1..NR-1 (equivalent inverse cipher).
module aes_dec_key_sched
  import aes_dec_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid_i,
  output logic             key_ready_o,
  input  logic [KEY_W-1:0] key_i,
  input  logic             rk_req_i,
  input  logic [IDX_W-1:0] rk_idx_i,
  output logic [KEY_W-1:0] rk_o,
  output logic             rk_valid_o,
  output logic             sched_done_o,
  output logic             busy_o
);

  ks_state_e        state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             accept, rd_fire;

  state_t           rf_q [NR+1];
  state_t           cur_q;
  state_t           next_key;
  state_t           rk_q, rk_d;
  logic             rk_valid_q;
  logic [IDX_W-1:0] rd_idx;

  word_t            rot, sub, temp;
  word_t            n0, n1, n2, n3;

  // ---------------------------------------------------------------- control
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    key_ready_o  = 1'b0;
    busy_o       = 1'b0;
    sched_done_o = 1'b0;
    accept       = 1'b0;
    rd_fire      = 1'b0;
    unique case (state_q)
      IDLE, READY: begin
        key_ready_o  = 1'b1;
        sched_done_o = (state_q == READY);
        if (key_valid_i) begin
          accept  = 1'b1;
          state_d = EXPAND;
          cnt_d   = IDX_W'(1);
        end else if (rk_req_i && state_q == READY) begin
          rd_fire = 1'b1;
        end
      end
      EXPAND: begin
        busy_o = 1'b1;
        if (cnt_q == IDX_W'(NR)) begin
          state_d = READY;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- expansion round
  assign rot = rot_word(cur_q[31:0]);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .in_i  (rot[8*i +: 8]),
      .out_o (sub[8*i +: 8])
    );
  end

  assign temp     = sub ^ {RCON[cnt_q], 24'h000000};
  assign n0       = cur_q[127:96] ^ temp;
  assign n1       = cur_q[95:64]  ^ n0;
  assign n2       = cur_q[63:32]  ^ n1;
  assign n3       = cur_q[31:0]   ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // ---------------------------------------------------------------- read path
  assign rd_idx = IDX_W'(NR) - rk_idx_i;

  always_comb begin
    rk_d = '0;
    if (rk_idx_i <= IDX_W'(NR)) begin
      rk_d = rf_q[rd_idx];
`ifdef AES_EQINV_KEY_EN
      if (rk_idx_i != '0 && rk_idx_i != IDX_W'(NR)) begin
        rk_d = inv_mix_columns(rf_q[rd_idx]);
      end
`endif
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rk_q       <= '0;
      rk_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rk_valid_q <= rd_fire;
      if (rd_fire) begin
        rk_q <= rk_d;
      end
    end
  end

  // NOTE: the key store has no reset; it is only read in READY, after a full expansion rewrote it.
  always_ff @(posedge clk) begin
    if (accept) begin
      rf_q[0] <= key_i;
      cur_q   <= key_i;
    end else if (state_q == EXPAND) begin
      rf_q[cnt_q] <= next_key;
      cur_q       <= next_key;
    end
  end

  assign rk_o       = rk_q;
  assign rk_valid_o = rk_valid_q;

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Self-checking bench: FIPS-197 vectors plus random keys against a word-array key-expansion model.
module tb_aes_dec_key_sched;

  localparam int NR = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid_i, key_ready_o;
  logic [127:0] key_i, rk_o;
  logic         rk_req_i, rk_valid_o, sched_done_o, busy_o;
  logic [3:0]   rk_idx_i;

  int           n_vec = 0;
  int           n_err = 0;
  logic [7:0]   sbox_m [256];
  logic [127:0] ref_rk [NR+1];
  logic [127:0] exp_rk_o;

  always #5 clk = ~clk;

  aes_dec_key_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid_i  (key_valid_i),
    .key_ready_o  (key_ready_o),
    .key_i        (key_i),
    .rk_req_i     (rk_req_i),
    .rk_idx_i     (rk_idx_i),
    .rk_o         (rk_o),
    .rk_valid_o   (rk_valid_o),
    .sched_done_o (sched_done_o),
    .busy_o       (busy_o)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = (a == 0) ? 8'h00 : 8'(a);
      if (a != 0) begin
        for (int k = 0; k < 253; k++) inv = gf_mul(inv, 8'(a));
      end
      sbox_m[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic build_model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rc, 24'h0};
        rc = gf_mul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] inv_mix_model(input logic [127:0] k);
    logic [7:0]   coef [4];
    logic [7:0]   a [4];
    logic [7:0]   o;
    logic [127:0] r;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = k[127-32*c-8*j -: 8];
      for (int row = 0; row < 4; row++) begin
        o = 8'h00;
        for (int j = 0; j < 4; j++) o = o ^ gf_mul(coef[(j - row + 4) % 4], a[j]);
        r[127-32*c-8*row -: 8] = o;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] xform(input int d, input logic [127:0] raw);
`ifdef AES_EQINV_KEY_EN
    if (d >= 1 && d <= NR - 1) return inv_mix_model(raw);
`endif
    return raw;
  endfunction

  function automatic logic [127:0] exp_key(input int d);
    if (d > NR) return '0;
    return xform(d, ref_rk[NR-d]);
  endfunction

  // ---------------------------------------------------------------- stimulus tasks
  task automatic load_key(input logic [127:0] k, input bit with_req);
    int lat;
    key_valid_i = 1'b1;
    key_i       = k;
    rk_req_i    = with_req;
    rk_idx_i    = 4'($urandom_range(0, NR));
    @(negedge clk);
    lat = 1;
    key_valid_i = 1'b0;
    check("accept_ready_low", key_ready_o, 1'b0);
    check("accept_busy", busy_o, 1'b1);
    check("accept_done_clr", sched_done_o, 1'b0);
    check("accept_req_dropped", rk_valid_o, 1'b0);
    check("accept_rk_hold", rk_o, exp_rk_o);
    rk_req_i    = 1'b1;
    rk_idx_i    = 4'($urandom_range(0, NR));
    key_valid_i = 1'b1;
    key_i       = ~k;
    @(negedge clk);
    lat = 2;
    rk_req_i    = 1'b0;
    key_valid_i = 1'b0;
    key_i       = k;
    check("expand_req_ignored", rk_valid_o, 1'b0);
    check("expand_rk_hold", rk_o, exp_rk_o);
    while (sched_done_o !== 1'b1 && lat < 40) begin
      check("expand_busy", busy_o, 1'b1);
      @(negedge clk);
      lat++;
    end
    check("done_latency", lat, NR + 1);
    check("done_busy_low", busy_o, 1'b0);
    check("done_ready", key_ready_o, 1'b1);
    build_model(k);
  endtask

  task automatic read_fixed(input int d, input logic [127:0] raw);
    rk_req_i = 1'b1;
    rk_idx_i = 4'(d);
    @(negedge clk);
    rk_req_i = 1'b0;
    exp_rk_o = xform(d, raw);
    check("fixed_valid", rk_valid_o, 1'b1);
    check($sformatf("fixed_rk_d%0d", d), rk_o, exp_rk_o);
  endtask

  task automatic burst(input int n);
    bit pend;
    int pidx;
    for (int i = 0; i < n; i++) begin
      pend     = ($urandom_range(0, 3) != 0);
      pidx     = $urandom_range(0, 13);
      rk_req_i = pend;
      rk_idx_i = 4'(pidx);
      @(negedge clk);
      if (pend) exp_rk_o = exp_key(pidx);
      check("burst_valid", rk_valid_o, pend);
      check($sformatf("burst_rk_d%0d", pidx), rk_o, exp_rk_o);
    end
    rk_req_i = 1'b0;
    @(negedge clk);
    check("burst_pulse_end", rk_valid_o, 1'b0);
    check("burst_rk_hold", rk_o, exp_rk_o);
  endtask

  // ---------------------------------------------------------------- main sequence
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k;
    build_sbox();
    rst_n       = 1'b0;
    key_valid_i = 1'b0;
    key_i       = '0;
    rk_req_i    = 1'b0;
    rk_idx_i    = '0;
    exp_rk_o    = '0;
    repeat (3) @(negedge clk);
    check("rst_key_ready", key_ready_o, 1'b1);
    check("rst_rk", rk_o, '0);
    check("rst_rk_valid", rk_valid_o, 1'b0);
    check("rst_done", sched_done_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    rk_req_i = 1'b1;
    rk_idx_i = 4'd0;
    @(negedge clk);
    rk_req_i = 1'b0;
    check("idle_req_ignored", rk_valid_o, 1'b0);

    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
    read_fixed(0,  128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_fixed(10, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    read_fixed(9,  128'ha0fafe1788542cb123a339392a6c7605);
    read_fixed(12, 128'h0);
    burst(24);

    // Reset five cycles into an expansion must discard it completely.
    key_valid_i = 1'b1;
    key_i       = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    @(negedge clk);
    key_valid_i = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_rk_o = '0;
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_done", sched_done_o, 1'b0);
    check("midrst_ready", key_ready_o, 1'b1);
    check("midrst_valid", rk_valid_o, 1'b0);
    check("midrst_rk", rk_o, exp_rk_o);
    @(negedge clk);
    rst_n    = 1'b1;
    rk_req_i = 1'b1;
    rk_idx_i = 4'd0;
    @(negedge clk);
    rk_req_i = 1'b0;
    check("post_rst_req_ignored", rk_valid_o, 1'b0);

    load_key(128'h000102030405060708090a0b0c0d0e0f, 1'b0);
    read_fixed(0, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    burst(20);

    for (int n = 0; n < 6; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      load_key(k, 1'($urandom_range(0, 1)));
      burst(16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_dec_key_sched.md
Name: aes_dec_key_sched

Overview:
- Iterative AES-128 key expansion engine that feeds the inverse-round datapath of the decryption core.
- Accepts the 128-bit cipher key and generates round keys rk[0..10], one per cycle, into an internal register file.
- Serves round keys in decryption order: decryption round d receives rk[10-d].
- Sits directly upstream of the AddRoundKey/inverse-round logic built from the core's gate-level cells.

Parameters:
- NR, 10, number of rounds (AES-128 only; other values unsupported).
- KEY_W, 128, key and round-key width in bits.
- IDX_W, 4, width of the round-index request port.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key_valid_i  in  1  cipher key present on key_i.
- key_ready_o  out  1  engine can accept a key.
- key_i  in  KEY_W  cipher key; byte 0 in bits [127:120].
- rk_req_i  in  1  round-key read request.
- rk_idx_i  in  IDX_W  decryption round index d, 0..NR.
- rk_o  out  KEY_W  requested round key, registered.
- rk_valid_o  out  1  rk_o valid this cycle.
- sched_done_o  out  1  all round keys stored; level signal.
- busy_o  out  1  expansion in progress.

Behaviour:
- Clock and reset decided: single clock clk; rst_n is asynchronous, active-low.
- Reset values: key_ready_o=1, rk_o=0, rk_valid_o=0, sched_done_o=0, busy_o=0, state=IDLE, round counter=0. The register file is not reset.
- FSM states: IDLE, EXPAND, READY.
- IDLE/READY:
  - key_ready_o=1.
  - On key_valid_i&key_ready_o: store key_i as rk[0], set counter=1, clear sched_done_o, go to EXPAND.
- EXPAND:
  - key_ready_o=0, busy_o=1.
  - Each cycle compute rk[cnt] from rk[cnt-1]: RotWord, 4 parallel S-box lookups, Rcon[cnt], then XOR chain w0..w3.
  - Store rk[cnt] and increment cnt.
  - After storing rk[NR], go to READY: sched_done_o=1, busy_o=0.
  - Key accepted at cycle T gives sched_done_o=1 at T+NR+1.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36, indexed by cnt 1..10.
- Read path, 1-cycle latency:
  - If rk_req_i in READY and rk_idx_i<=NR: next cycle rk_o=rk[NR-rk_idx_i] and rk_valid_o=1.
  - rk_idx_i>NR: rk_o=0, rk_valid_o=1.
  - rk_req_i outside READY: ignored; rk_valid_o=0 and rk_o holds.
- rk_valid_o is a one-cycle pulse per request. Back-to-back requests are supported, one per cycle.
- Simultaneous key accept and rk_req_i in READY: accept wins, request dropped, rk_valid_o=0.
- key_valid_i during EXPAND: ignored, not queued. Upstream holds the key until ready.
- rst_n asserted mid-EXPAND: immediate return to IDLE. Partial keys are discarded, sched_done_o=0.

Optional Feature:
- Macro AES_EQINV_KEY_EN.
- Defined:
  - Equivalent-inverse-cipher schedule: keys read for d=1..NR-1 are InvMixColumns(rk[NR-d]), applied on the read path before the rk_o register. Latency stays 1 cycle.
  - d=0 and d=NR are returned raw.
- Undefined: all keys are returned raw and no InvMixColumns logic is instantiated.

Decomposition:
- Package aes_dec_pkg:
  - constants NR, KEY_W, RCON array;
  - typedefs word_t (32b), state_t (128b), ks_state_e (IDLE/EXPAND/READY);
  - functions xtime, rot_word.
- Sub-module aes_sbox: forward S-box, 8b in / 8b out, combinational, instantiated 4 times.
- When AES_EQINV_KEY_EN is defined, the InvMixColumns function is also placed in aes_dec_pkg.

Test Plan:
- Reset, then key 2b7e151628aed2a6abf7158809cf4f3c accepted at cycle T -> busy_o high T+1..T+10; sched_done_o=1 at T+11.
- After done, request d=0 -> next cycle rk_o=d014f9a8c9ee2589e13f0cc8b6630ca6, rk_valid_o=1.
- Request d=10 -> rk_o=2b7e151628aed2a6abf7158809cf4f3c. Request d=9 -> rk_o=a0fafe1788542cb123a339392a6c7605.
- Request d=12 -> rk_o=0, rk_valid_o=1. Request during EXPAND -> rk_valid_o stays 0.
- Assert rst_n=0 at T+5 and release, then load key 000102030405060708090a0b0c0d0e0f -> d=0 returns 13111d7fe3944a17f307a78b4d2b30c5, with no stale data.
- With AES_EQINV_KEY_EN defined: d=1..9 match InvMixColumns of the reference-model keys; d=0 and d=10 are unchanged from the raw schedule.
